// File: rtl/audio_tx_fifo.sv
// Slave-mode I2S / left-justified serial audio transmitter fed from a stereo
// frame FIFO, with underrun detection/counting and mute.
module audio_tx_fifo #(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned SLOT_W          = 32,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned FORMAT          = 0,
    parameter bit          LEFT_LRC        = 1'b1,
    parameter bit          UNDERRUN_REPEAT = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sck_bclk,
    input  logic                          ws_lrc,
    output logic                          sdata,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_left,
    input  logic [DATA_W-1:0]             in_right,
    input  logic                          mute,
    output logic                          frame_start,
    output logic                          underrun,
    output logic [15:0]                   underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [5:0]  BITS  = 6'(SLOT_W);

    logic             bclk_m, bclk_s, bclk_d;
    logic             lrc_m, lrc_s, lrc_d;
    logic [1:0]       warm;
    logic             sync_ok, bclk_fall, slot_edge, left_edge, right_edge;
    logic             armed;

    logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              push, pop, fifo_empty;

    logic [DATA_W-1:0] next_l, next_r, last_l, last_r, right_stage;
    logic [SLOT_W-1:0] shreg, load_word;
    logic [5:0]        bit_cnt;
    logic              load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {bclk_m, bclk_s, bclk_d} <= '0;
            {lrc_m, lrc_s, lrc_d}    <= '0;
            warm                     <= '0;
        end else begin
            bclk_m <= sck_bclk;
            bclk_s <= bclk_m;
            bclk_d <= bclk_s;
            lrc_m  <= ws_lrc;
            lrc_s  <= lrc_m;
            lrc_d  <= lrc_s;
            if (warm != 2'd3) warm <= warm + 2'd1;
        end
    end

    // Edges are ignored until the edge-detect flop holds a real sample, so the
    // reset value of the synchronisers cannot fake an lrc transition.
    assign sync_ok    = (warm == 2'd3);
    assign bclk_fall  = sync_ok && bclk_d && !bclk_s;
    assign slot_edge  = sync_ok && (lrc_s != lrc_d);
    assign left_edge  = slot_edge && (lrc_s == LEFT_LRC);
    assign right_edge = slot_edge && (lrc_s != LEFT_LRC) && armed;
    assign load       = left_edge || right_edge;

    assign fifo_empty = (level == '0);
    assign in_ready   = (level != LVL_W'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = left_edge && !fifo_empty;
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr] <= in_left;
            mem_r[wr_ptr] <= in_right;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_comb begin
        next_l = '0;
        next_r = '0;
        if (!fifo_empty) begin
            next_l = mem_l[rd_ptr];
            next_r = mem_r[rd_ptr];
        end else if (UNDERRUN_REPEAT) begin
            next_l = last_l;
            next_r = last_r;
        end
        if (mute) begin
            next_l = '0;
            next_r = '0;
        end
    end

    always_comb begin
        load_word = '0;
        if (left_edge) load_word[SLOT_W-1 -: DATA_W] = next_l;
        else           load_word[SLOT_W-1 -: DATA_W] = right_stage;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed        <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            right_stage  <= '0;
            last_l       <= '0;
            last_r       <= '0;
        end else begin
            frame_start <= left_edge;
            underrun    <= left_edge && fifo_empty;
            if (left_edge) begin
                armed       <= 1'b1;
                right_stage <= next_r;
                last_l      <= next_l;
                last_r      <= next_r;
                if (fifo_empty && underrun_cnt != '1)
                    underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            sdata   <= 1'b0;
        end else if (load) begin
            if (FORMAT == 1) begin
                sdata   <= load_word[SLOT_W-1];
                shreg   <= load_word << 1;
                bit_cnt <= 6'd1;
            end else begin
                // The lrc edge arrives on a bclk fall, which still owes the
                // previous slot its final bit.
                if (bclk_fall) sdata <= (bit_cnt < BITS) ? shreg[SLOT_W-1] : 1'b0;
                shreg   <= load_word;
                bit_cnt <= '0;
            end
        end else if (bclk_fall) begin
            if (bit_cnt < BITS) begin
                sdata   <= shreg[SLOT_W-1];
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + 6'd1;
            end else begin
                sdata <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_tx_fifo.sv
// Scoreboard bench: two transmitters (I2S/zero-fill and left-justified/repeat)
// share one codec; a bclk-rising monitor rebuilds frames and checks them.
module tb_audio_tx_fifo;
    localparam int HALF = 8;

    logic        clk = 1'b0, rst_n = 1'b0, bclk = 1'b1, lrc = 1'b0;
    logic        in_valid = 1'b0, mute = 1'b0;
    logic [15:0] in_left = '0, in_right = '0;
    logic        sdata_a, sdata_b, rdy_a, rdy_b, fs_a, fs_b, ur_a, ur_b;
    logic [15:0] ucnt_a, ucnt_b;
    logic [2:0]  lvl_a, lvl_b;

    int checks = 0, failures = 0;
    int fs_n[2], ur_n[2];
    logic [63:0] exp_q0[$], exp_q1[$];
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    audio_tx_fifo #(.DATA_W(16), .SLOT_W(32), .FIFO_DEPTH(4), .FORMAT(0),
                    .LEFT_LRC(1'b1), .UNDERRUN_REPEAT(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .sck_bclk(bclk), .ws_lrc(lrc), .sdata(sdata_a),
        .in_valid(in_valid), .in_ready(rdy_a), .in_left(in_left), .in_right(in_right),
        .mute(mute), .frame_start(fs_a), .underrun(ur_a), .underrun_cnt(ucnt_a),
        .fifo_level(lvl_a));

    audio_tx_fifo #(.DATA_W(16), .SLOT_W(32), .FIFO_DEPTH(4), .FORMAT(1),
                    .LEFT_LRC(1'b1), .UNDERRUN_REPEAT(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .sck_bclk(bclk), .ws_lrc(lrc), .sdata(sdata_b),
        .in_valid(in_valid), .in_ready(rdy_b), .in_left(in_left), .in_right(in_right),
        .mute(mute), .frame_start(fs_b), .underrun(ur_b), .underrun_cnt(ucnt_b),
        .fifo_level(lvl_b));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fs_a) fs_n[0]++;
        if (fs_b) fs_n[1]++;
        if (ur_a) ur_n[0]++;
        if (ur_b) ur_n[1]++;
    end

    // Codec-side receiver: I2S data at rises 2..33 of a slot, left-justified at 1..32.
    int          pos = 0;
    logic        last_lrc = 1'b0;
    logic [31:0] acc[2], left_w[2];
    int          nb[2];
    bit          coll[2], got_left[2];
    logic        cside[2];

    always @(posedge bclk) begin
        logic        sd;
        logic [63:0] e;
        if (lrc !== last_lrc) begin
            pos = 1;
            last_lrc = lrc;
        end else pos++;
        for (int m = 0; m < 2; m++) begin
            sd = (m == 0) ? sdata_a : sdata_b;
            if (!mon_en) begin
                coll[m] = 1'b0;
                got_left[m] = 1'b0;
            end else begin
                if (pos == ((m == 0) ? 2 : 1)) begin
                    acc[m] = '0; nb[m] = 0; coll[m] = 1'b1; cside[m] = lrc;
                end
                if (coll[m]) begin
                    acc[m] = {acc[m][30:0], sd};
                    nb[m]++;
                    if (nb[m] == 32) begin
                        coll[m] = 1'b0;
                        if (cside[m]) begin
                            left_w[m] = acc[m];
                            got_left[m] = 1'b1;
                        end else if (got_left[m]) begin
                            got_left[m] = 1'b0;
                            if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
                                checks++; failures++;
                                $display("FAIL frame_%0d: got %0h expected no frame", m, {left_w[m], acc[m]});
                            end else begin
                                e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                                check((m == 0) ? "frame_i2s" : "frame_lj", {left_w[m], acc[m]}, e);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic half_bclk(); repeat (HALF) @(negedge clk); endtask
    task automatic bclk_cycle(); bclk = 1'b0; half_bclk(); bclk = 1'b1; half_bclk(); endtask
    task automatic slot(input logic lvl, input int n);
        lrc = lvl;
        for (int i = 0; i < n; i++) bclk_cycle();
    endtask
    task automatic frames(input int n, input bit tail);
        for (int f = 0; f < n; f++) begin slot(1'b1, 32); slot(1'b0, 32); end
        if (tail) bclk_cycle();
    endtask
    task automatic push(input logic [15:0] l, input logic [15:0] r);
        in_left = l; in_right = r; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask
    task automatic expect_both(input logic [63:0] fa, input logic [63:0] fb);
        exp_q0.push_back(fa);
        exp_q1.push_back(fb);
    endtask

    logic [15:0] fl[6] = '{16'hA5A5, 16'h0F0F, 16'hFFFF, 16'h0001, 16'hDEAD, 16'hBEEF};
    logic [15:0] fr[6] = '{16'h5A5A, 16'hF0F0, 16'h8000, 16'h7FFF, 16'hCAFE, 16'hF00D};

    initial begin
        bit quiet_bad;
        repeat (3) @(negedge clk);
        check("rst_sdata_a", sdata_a, 0);
        check("rst_sdata_b", sdata_b, 0);
        check("rst_ready", rdy_a, 1);
        check("rst_level", lvl_a, 0);
        check("rst_ucnt", ucnt_a, 0);
        check("rst_pulses", {fs_a, ur_a}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        mon_en = 1'b1;

        // Basic frames: LJ shows MSB right after the lrc edge, I2S one bclk later
        push(16'h8001, 16'h7FFE);
        push(16'h8001, 16'h7FFE);
        check("level_two", lvl_a, 2);
        expect_both(64'h8001_0000_7FFE_0000, 64'h8001_0000_7FFE_0000);
        expect_both(64'h8001_0000_7FFE_0000, 64'h8001_0000_7FFE_0000);
        lrc = 1'b1; bclk = 1'b0;
        repeat (4) @(negedge clk);
        check("lj_msb_latency", sdata_b, 1);
        check("i2s_msb_delayed", sdata_a, 0);
        repeat (HALF - 4) @(negedge clk);
        bclk = 1'b1; half_bclk();
        slot(1'b1, 31); slot(1'b0, 32);
        frames(1, 1'b1);
        check("fs_count_a", fs_n[0], 2);
        check("fs_count_b", fs_n[1], 2);
        check("no_underrun", ur_n[0], 0);
        check("level_drained", lvl_a, 0);

        // Underrun: zeros on dut_a, last frame repeated on dut_b
        push(16'h1234, 16'hABCD);
        expect_both(64'h1234_0000_ABCD_0000, 64'h1234_0000_ABCD_0000);
        for (int i = 0; i < 3; i++) expect_both(64'h0, 64'h1234_0000_ABCD_0000);
        frames(4, 1'b1);
        check("ucnt_a", ucnt_a, 3);
        check("ucnt_b", ucnt_b, 3);
        check("ur_pulses_a", ur_n[0], 3);
        check("ur_pulses_b", ur_n[1], 3);

        // Fill to full with in_valid held, then drain one and mute the middle frame
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_left = fl[i]; in_right = fr[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("full_ready", rdy_a, 0);
        check("full_level_a", lvl_a, 4);
        check("full_level_b", lvl_b, 4);
        expect_both({fl[0], 16'h0, fr[0], 16'h0}, {fl[0], 16'h0, fr[0], 16'h0});
        frames(1, 1'b0);
        check("pop_level", lvl_a, 3);
        check("pop_ready", rdy_a, 1);
        expect_both({fl[1], 16'h0, fr[1], 16'h0}, {fl[1], 16'h0, fr[1], 16'h0});
        expect_both(64'h0, 64'h0);
        expect_both({fl[3], 16'h0, fr[3], 16'h0}, {fl[3], 16'h0, fr[3], 16'h0});
        frames(1, 1'b0);
        mute = 1'b1;
        frames(1, 1'b0);
        mute = 1'b0;
        frames(1, 1'b1);
        check("mute_no_underrun", ur_n[0], 3);
        check("mute_level", lvl_a, 0);
        check("fs_count_mute", fs_n[0], 10);

        // Reset mid left slot, release mid right slot
        mon_en = 1'b0;
        push(16'hFFFF, 16'hFFFF);
        slot(1'b1, 10);
        check("pre_rst_sdata_a", sdata_a, 1);
        check("pre_rst_sdata_b", sdata_b, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_sdata_a", sdata_a, 0);
        check("async_sdata_b", sdata_b, 0);
        check("async_level", lvl_a, 0);
        @(negedge clk);
        for (int i = 0; i < 22; i++) bclk_cycle();
        slot(1'b0, 8);
        rst_n = 1'b1;
        push(16'h00F0, 16'h0F00);
        quiet_bad = 1'b0;
        for (int i = 0; i < 24; i++) begin
            bclk_cycle();
            if (sdata_a !== 1'b0 || sdata_b !== 1'b0 || lvl_a !== 3'd1) quiet_bad = 1'b1;
        end
        check("rst_rearm_quiet", quiet_bad, 0);
        check("rst_fs_count", fs_n[0], 11);
        check("rst_ucnt", ucnt_a, 0);
        mon_en = 1'b1;
        expect_both(64'h00F0_0000_0F00_0000, 64'h00F0_0000_0F00_0000);
        frames(1, 1'b1);
        check("rearm_level", lvl_a, 0);
        check("rearm_fs_count", fs_n[1], 12);
        check("rearm_no_underrun", ucnt_b, 0);

        check("q_i2s_drained", exp_q0.size(), 0);
        check("q_lj_drained", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
